// File: rtl/mem_resp_pkg.sv
// Shared types for the memory responder: request control struct, FSM states
// and the width of the wait-cycle counter.
package mem_resp_pkg;

  localparam int MEM_LAT_W = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_wr_e;

  typedef struct packed {
    logic    mem_en;
    mem_wr_e wr;
  } MEM_ctrl;

  typedef enum logic {
    MR_IDLE,
    MR_WAIT
  } mem_resp_state;

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word array with per-byte write enables and a registered read.
// The array itself is never reset.
module sram_1rw_be #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // The read register only moves on a read, so it holds across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_resp.sv
// Memory-side responder: accepts one request at a time, holds BUSY for
// LATENCY cycles, commits the access and pulses RVALID (and ERR if out of range).
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                LATENCY   = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              REQ_in,
  input  MEM_ctrl           MEMctrl_in,
  input  logic [ADDR_W-1:0] ADDR_in,
  input  logic [DATA_W-1:0] WDATA_in,
  input  logic [3:0]        BE_in,
  output logic              BUSY_out,
  output logic [DATA_W-1:0] RDATA_out,
  output logic              RVALID_out,
  output logic              ERR_out
);

  localparam int                   IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0]      SPAN      = (ADDR_W+1)'(DEPTH) << 2;
  localparam bit                   FAST      = (LATENCY <= 1);
  localparam bit                   COMB_BUSY = (LATENCY != 0);
  localparam logic [MEM_LAT_W-1:0] CNT_LOAD  =
    (LATENCY >= 2) ? MEM_LAT_W'(LATENCY - 2) : '0;

  mem_resp_state        state;
  logic [MEM_LAT_W-1:0] cnt;
  logic [ADDR_W-1:0]    h_addr;
  logic [DATA_W-1:0]    h_wdata;
  logic [3:0]           h_be;
  mem_wr_e              h_wr;
  logic                 busy_q;
  logic                 rvalid_q;
  logic                 err_q;
  logic                 rd_zero;

  logic                 accept;
  logic                 commit;
  logic [ADDR_W-1:0]    c_addr;
  logic [DATA_W-1:0]    c_wdata;
  logic [3:0]           c_be;
  mem_wr_e              c_wr;
  logic [ADDR_W-1:0]    c_off;
  logic                 c_in_range;
  logic [DATA_W-1:0]    sram_rdata;

  assign accept = (state == MR_IDLE) && REQ_in && MEMctrl_in.mem_en;

  // Zero/one-wait accesses commit on the accept edge straight from the inputs;
  // longer ones commit from the holding registers once the counter runs out.
  assign commit  = FAST ? accept : ((state == MR_WAIT) && (cnt == '0));
  assign c_addr  = FAST ? ADDR_in    : h_addr;
  assign c_wdata = FAST ? WDATA_in   : h_wdata;
  assign c_be    = FAST ? BE_in      : h_be;
  assign c_wr    = FAST ? MEMctrl_in.wr : h_wr;

  assign c_off      = c_addr - BASE_ADDR;
  assign c_in_range = (c_addr >= BASE_ADDR) && ({1'b0, c_off} < SPAN);

  sram_1rw_be #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_sram (
    .clk   (CLK),
    .en    (commit && c_in_range),
    .we    (c_wr == WRITE),
    .be    (c_be),
    .idx   (c_off[IDX_W+1:2]),
    .wdata (c_wdata),
    .rdata (sram_rdata)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= MR_IDLE;
      cnt      <= '0;
      h_addr   <= '0;
      h_wdata  <= '0;
      h_be     <= '0;
      h_wr     <= READ;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      rvalid_q <= commit;
      err_q    <= commit && !c_in_range;
      if (commit && (c_wr == READ)) rd_zero <= !c_in_range;

      case (state)
        MR_IDLE: begin
          if (accept) begin
            h_addr  <= ADDR_in;
            h_wdata <= WDATA_in;
            h_be    <= BE_in;
            h_wr    <= MEMctrl_in.wr;
            if (!FAST) begin
              state  <= MR_WAIT;
              cnt    <= CNT_LOAD;
              busy_q <= 1'b1;
            end
          end
        end
        MR_WAIT: begin
          if (cnt == '0) begin
            state  <= MR_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= MR_IDLE;
      endcase
    end
  end

  // The accept-cycle BUSY is combinational so the pipeline stalls immediately.
  assign BUSY_out   = busy_q | (RSTn & accept & COMB_BUSY);
  assign RDATA_out  = rd_zero ? '0 : sram_rdata;
  assign RVALID_out = rvalid_q;
  assign ERR_out    = err_q;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: one instance per latency 0..4, directed
// scenarios followed by randomized accesses against a word-array model.
module tb_mem_resp;
  import mem_resp_pkg::*;

  localparam int          NI       = 5;
  localparam int          DEPTH_TB = 64;
  localparam logic [31:0] BASE_TB  = 32'h0000_0100;
  localparam logic [31:0] END_TB   = BASE_TB + 32'(4 * DEPTH_TB);
  localparam int          LATS [NI] = '{0, 1, 2, 3, 4};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] req;
  MEM_ctrl       ctrl;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          busy   [NI];
  logic [31:0]   rdata  [NI];
  logic          rvalid [NI];
  logic          err    [NI];

  logic [31:0] model_mem [NI][DEPTH_TB];
  logic [31:0] model_rd  [NI];
  bit          rv_now;
  int          last_sel;
  int          vectors    = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_resp #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .DEPTH     (DEPTH_TB),
      .BASE_ADDR (BASE_TB),
      .LATENCY   (LATS[g])
    ) u_dut (
      .CLK        (clk),
      .RSTn       (rst_n),
      .REQ_in     (req[g]),
      .MEMctrl_in (ctrl),
      .ADDR_in    (addr),
      .WDATA_in   (wdata),
      .BE_in      (be),
      .BUSY_out   (busy[g]),
      .RDATA_out  (rdata[g]),
      .RVALID_out (rvalid[g]),
      .ERR_out    (err[g])
    );
  end

  function automatic bit in_range(input logic [31:0] a);
    return ({32'b0, a} >= {32'b0, BASE_TB}) && ({32'b0, a} < {32'b0, END_TB});
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a - BASE_TB) >> 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic scramble(input int sel, input bit fire);
    req      = '0;
    req[sel] = fire;
    ctrl.mem_en = 1'($urandom_range(0, 1)) | fire;
    ctrl.wr  = mem_wr_e'($urandom_range(0, 1));
    addr     = $urandom;
    wdata    = $urandom;
    be       = 4'($urandom);
  endtask

  // Drives one access in the current cycle and follows it to its RVALID cycle.
  task automatic applyStimulus(input int sel, input bit wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] b);
    int lat;
    int eff;
    bit ok;
    lat = LATS[sel];
    eff = (lat < 1) ? 1 : lat;
    ok  = in_range(a);
    if (wr && ok) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) model_mem[sel][word_idx(a)][8*i +: 8] = d[8*i +: 8];
    end
    if (!wr) model_rd[sel] = ok ? model_mem[sel][word_idx(a)] : 32'h0;

    req         = '0;
    req[sel]    = 1'b1;
    ctrl.mem_en = 1'b1;
    ctrl.wr     = wr ? WRITE : READ;
    addr        = a;
    wdata       = d;
    be          = b;
    #1;
    checkOutput($sformatf("L%0d busy k0", lat), 32'(busy[sel]), 32'(lat != 0));
    checkOutput($sformatf("L%0d rvalid k0", lat), 32'(rvalid[sel]),
                32'(rv_now && (last_sel == sel)));
    for (int k = 1; k <= eff; k++) begin
      @(negedge clk);
      // A forced extra request in the first wait cycle must be ignored.
      if (k < eff) scramble(sel, (k == 1) ? 1'b1 : 1'($urandom_range(0, 1)));
      else         scramble(sel, 1'b0);
      #1;
      checkOutput($sformatf("L%0d busy k%0d", lat, k), 32'(busy[sel]), 32'(k < lat));
      checkOutput($sformatf("L%0d rvalid k%0d", lat, k), 32'(rvalid[sel]), 32'(k == eff));
      if (k == eff) begin
        checkOutput($sformatf("L%0d err a=%h", lat, a), 32'(err[sel]), 32'(!ok));
        checkOutput($sformatf("L%0d rdata a=%h", lat, a), rdata[sel], model_rd[sel]);
      end
    end
    req      = '0;
    rv_now   = 1'b1;
    last_sel = sel;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    req = '0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("idle busy L%0d", LATS[i]), 32'(busy[i]), 32'h0);
      checkOutput($sformatf("idle rvalid L%0d", LATS[i]), 32'(rvalid[i]), 32'h0);
      checkOutput($sformatf("idle err L%0d", LATS[i]), 32'(err[i]), 32'h0);
      checkOutput($sformatf("idle rdata L%0d", LATS[i]), rdata[i], model_rd[i]);
    end
    rv_now = 1'b0;
  endtask

  // Starts a write, then pulls reset in the middle of its wait period.
  task automatic applyAbort(input int sel, input logic [31:0] a, input logic [31:0] d);
    req         = '0;
    req[sel]    = 1'b1;
    ctrl.mem_en = 1'b1;
    ctrl.wr     = WRITE;
    addr        = a;
    wdata       = d;
    be          = 4'hF;
    #1;
    checkOutput("abort busy k0", 32'(busy[sel]), 32'h1);
    @(negedge clk);
    scramble(sel, 1'b0);
    #1;
    checkOutput("abort busy k1", 32'(busy[sel]), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy async drop", 32'(busy[sel]), 32'h0);
    @(negedge clk);
    checkOutput("abort rvalid in reset", 32'(rvalid[sel]), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) model_rd[i] = 32'h0;
    rv_now = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    req   = '0;
    ctrl  = '{mem_en: 1'b0, wr: READ};
    addr  = '0;
    wdata = '0;
    be    = '0;
    rv_now   = 1'b0;
    last_sel = 0;
    for (int i = 0; i < NI; i++) model_rd[i] = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput("reset busy", 32'(busy[i]), 32'h0);
      checkOutput("reset rvalid", 32'(rvalid[i]), 32'h0);
      checkOutput("reset err", 32'(err[i]), 32'h0);
      checkOutput("reset rdata", rdata[i], 32'h0);
    end
    rst_n = 1'b1;
    idleCycle();

    $display("[TB] filling arrays with back-to-back writes");
    for (int s = 0; s < NI; s++) begin
      for (int w = 0; w < DEPTH_TB; w++)
        applyStimulus(s, 1'b1, BASE_TB + 32'(4 * w), $urandom, 4'hF);
      idleCycle();
    end

    $display("[TB] zero-wait write then read");
    applyStimulus(0, 1'b1, BASE_TB + 32'h10, 32'hDEAD_BEEF, 4'hF);
    idleCycle();
    applyStimulus(0, 1'b0, BASE_TB + 32'h10, 32'h0, 4'h0);
    checkOutput("zero-wait readback", rdata[0], 32'hDEAD_BEEF);
    idleCycle();

    $display("[TB] latency 3 read with back-to-back accept in RVALID cycle");
    applyStimulus(3, 1'b0, BASE_TB + 32'h20, 32'h0, 4'h0);
    applyStimulus(3, 1'b0, BASE_TB + 32'h24, 32'h0, 4'h0);
    idleCycle();

    $display("[TB] byte-enable merge");
    applyStimulus(2, 1'b1, BASE_TB + 32'h8, 32'h1122_3344, 4'hF);
    applyStimulus(2, 1'b1, BASE_TB + 32'h8, 32'hAABB_CCDD, 4'b0101);
    applyStimulus(2, 1'b0, BASE_TB + 32'hB, 32'h0, 4'h0);
    checkOutput("be merge", rdata[2], 32'h11BB_33DD);
    idleCycle();

    $display("[TB] out-of-range accesses");
    applyStimulus(2, 1'b0, END_TB, 32'h0, 4'h0);
    idleCycle();
    applyStimulus(2, 1'b1, BASE_TB - 32'h4, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(2, 1'b1, END_TB, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(2, 1'b0, END_TB - 32'h1, 32'h0, 4'h0);
    applyStimulus(2, 1'b0, BASE_TB, 32'h0, 4'h0);
    idleCycle();

    $display("[TB] latency 4 with ignored request during wait");
    applyStimulus(4, 1'b0, BASE_TB + 32'h30, 32'h0, 4'h0);
    idleCycle();

    $display("[TB] reset during wait aborts the write");
    applyAbort(4, BASE_TB + 32'h40, 32'hCAFE_F00D);
    repeat (5) idleCycle();
    applyStimulus(4, 1'b0, BASE_TB + 32'h40, 32'h0, 4'h0);
    idleCycle();

    $display("[TB] randomized accesses");
    for (int n = 0; n < 200; n++) begin
      int sel;
      sel = $urandom_range(0, NI - 1);
      case ($urandom_range(0, 9))
        0:       a = BASE_TB - 32'h4 - 32'($urandom_range(0, 252));
        1:       a = END_TB + 32'($urandom_range(0, 1000));
        default: a = BASE_TB + 32'($urandom_range(0, 4 * DEPTH_TB - 1));
      endcase
      applyStimulus(sel, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
      if ($urandom_range(0, 1) == 1) idleCycle();
    end
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
